// File: rtl/reg_slice_4bit.sv
// Two-entry valid/ready skid buffer that sits behind the 4-bit data register.
// s_ready is decoded from registered state only, so the upstream handshake never depends on m_ready.
module reg_slice_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             acc;
  logic             pop;

  assign s_ready = rst & (state != FULL);
  assign m_valid = (state != EMPTY);
  assign m_data  = main_q;
  assign acc     = s_valid & s_ready;
  assign pop     = m_valid & m_ready;

  always_comb begin
    occupancy = 2'd0;
    case (state)
      BUSY:    occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // The skid register only loads when the main word is stalled, so order is main then skid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            main_q <= s_data;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (acc && pop) begin
            main_q <= s_data;
          end else if (acc) begin
            skid_q <= s_data;
            state  <= FULL;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_q <= skid_q;
            state  <= BUSY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_slice_4bit.sv
// Directed and random checks of reg_slice_4bit against a two-deep FIFO queue model.
module tb_reg_slice_4bit;

  logic       clk;
  logic       rst;
  logic [3:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [3:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [1:0] occupancy;

  int         total;
  int         bad;
  logic [3:0] model_q[$];
  logic [3:0] last_data;

  reg_slice_4bit #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic sv, input logic [3:0] sd, input logic mr);
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
  endtask

  task automatic checkValue(input string tag, input logic [3:0] got, input logic [3:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  // Expected outputs follow from the queue: head is shown, size is the occupancy.
  task automatic checkOutput(input string tag);
    logic       exp_ready;
    logic       exp_valid;
    logic [1:0] exp_occ;
    exp_ready = rst && (model_q.size() < 2);
    exp_valid = (model_q.size() > 0);
    exp_occ   = 2'(model_q.size());
    checkValue({tag, ".s_ready"}, {3'b0, s_ready}, {3'b0, exp_ready});
    checkValue({tag, ".m_valid"}, {3'b0, m_valid}, {3'b0, exp_valid});
    checkValue({tag, ".occupancy"}, {2'b0, occupancy}, {2'b0, exp_occ});
    checkValue({tag, ".m_data"}, m_data, last_data);
  endtask

  task automatic stepCycle(input string tag);
    logic       acc;
    logic       pop;
    logic       stalled;
    logic [3:0] held;
    acc     = rst && s_valid && (model_q.size() < 2);
    pop     = rst && m_ready && (model_q.size() > 0);
    stalled = m_valid && !m_ready;
    held    = m_data;
    @(posedge clk);
    #1;
    if (pop) void'(model_q.pop_front());
    if (acc) model_q.push_back(s_data);
    if (model_q.size() > 0) last_data = model_q[0];
    checkOutput(tag);
    if (stalled) checkValue({tag, ".stall_hold"}, m_data, held);
  endtask

  task automatic resetModel();
    model_q.delete();
    last_data = 4'h0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    resetModel();
    rst = 1'b0;
    applyStimulus(1'b1, 4'hA, 1'b0);
    #2;
    checkOutput("reset_hold");
    stepCycle("reset_clk1");
    stepCycle("reset_clk2");

    applyStimulus(1'b0, 4'hA, 1'b0);
    rst = 1'b1;
    stepCycle("release");
    checkValue("release_ready", {3'b0, s_ready}, 4'h1);

    // Streaming at full rate
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 4'(i), 1'b1);
      stepCycle("stream");
      checkValue("stream_data", m_data, 4'(i));
      checkValue("stream_occ", {2'b0, occupancy}, 4'h1);
    end
    applyStimulus(1'b0, 4'h0, 1'b1);
    stepCycle("stream_drain");

    // Stall fills the skid, third word refused
    applyStimulus(1'b1, 4'h3, 1'b0);
    stepCycle("stall_a");
    applyStimulus(1'b1, 4'h5, 1'b0);
    stepCycle("stall_b");
    checkValue("stall_full_occ", {2'b0, occupancy}, 4'h2);
    applyStimulus(1'b1, 4'h7, 1'b0);
    stepCycle("stall_refuse");
    checkValue("stall_head", m_data, 4'h3);
    applyStimulus(1'b1, 4'h7, 1'b1);
    stepCycle("unstall_1");
    checkValue("unstall_5", m_data, 4'h5);
    applyStimulus(1'b1, 4'h7, 1'b1);
    stepCycle("unstall_2");
    checkValue("unstall_7", m_data, 4'h7);
    applyStimulus(1'b0, 4'h0, 1'b1);
    stepCycle("unstall_3");

    // Drain
    applyStimulus(1'b1, 4'h9, 1'b0);
    stepCycle("drain_fill9");
    applyStimulus(1'b1, 4'hC, 1'b0);
    stepCycle("drain_fillC");
    applyStimulus(1'b0, 4'h0, 1'b1);
    stepCycle("drain_1");
    checkValue("drain_C", m_data, 4'hC);
    stepCycle("drain_2");
    stepCycle("drain_3");
    checkValue("drain_hold", m_data, 4'hC);

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'($urandom), 4'($urandom), 1'($urandom));
      stepCycle("random");
    end
    applyStimulus(1'b0, 4'h0, 1'b1);
    stepCycle("random_drain1");
    stepCycle("random_drain2");

    // Reset while full discards both stored words
    applyStimulus(1'b1, 4'hE, 1'b0);
    stepCycle("mid_fillE");
    applyStimulus(1'b1, 4'h2, 1'b0);
    stepCycle("mid_fill2");
    checkValue("mid_full", {2'b0, occupancy}, 4'h2);
    rst = 1'b0;
    resetModel();
    #1;
    checkOutput("mid_reset_now");
    applyStimulus(1'b0, 4'h0, 1'b1);
    stepCycle("mid_reset_clk");
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      stepCycle("mid_after");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
